// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the ctrl_sequencer control FSM and its decoder:
// opcodes, ALU operations, FSM states and the decoded control word.
package ctrl_sequencer_pkg;

    localparam int OP_W = 4;

    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_AND   = 4'd1,
        OP_OR    = 4'd2,
        OP_XOR   = 4'd3,
        OP_SHL   = 4'd4,
        OP_SHR   = 4'd5,
        OP_ADDI  = 4'd6,
        OP_LD    = 4'd7,
        OP_ST    = 4'd8,
        OP_BZ    = 4'd9,
        OP_BNZ   = 4'd10,
        OP_JMP   = 4'd11,
        OP_JREG  = 4'd12,
        OP_SETPC = 4'd13,
        OP_NOP   = 4'd14,
        OP_HALT  = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic    pc_en;
        logic    branch_rel_nz;
        logic    branch_rel_z;
        logic    branch_abs;
        logic    reg_write_en;
        logic    reg_sel;
        logic    lut_in;
        logic    alu_src;
        logic    alu_sc_in;
        logic    read_mem;
        logic    write_mem;
        alu_op_t alu_op;
        logic    is_load;
        logic    is_halt;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps the latched {opcode,fcode}
// to the EXEC-state control word.
module ctrl_decode
    import ctrl_sequencer_pkg::*;
(
    input  opcode_t    op,
    input  logic       fcode,
    output ctrl_word_t cw
);

    always_comb begin
        cw        = '0;
        cw.alu_op = ALU_ADD;
        unique case (op)
            OP_ADD: begin
                cw.alu_op       = fcode ? ALU_SUB : ALU_ADD;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_AND: begin
                cw.alu_op       = ALU_AND;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_OR: begin
                cw.alu_op       = ALU_OR;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_XOR: begin
                cw.alu_op       = ALU_XOR;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_SHL: begin
                cw.alu_op       = ALU_SHL;
                cw.alu_sc_in    = fcode;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_SHR: begin
                cw.alu_op       = ALU_SHR;
                cw.alu_sc_in    = fcode;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_ADDI: begin
                cw.alu_op       = ALU_ADD;
                cw.alu_src      = 1'b1;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_LD: begin
                cw.read_mem = 1'b1;
                cw.is_load  = 1'b1;
            end
            OP_ST: begin
                cw.write_mem = 1'b1;
                cw.pc_en     = 1'b1;
            end
            OP_BZ: begin
                cw.branch_rel_z = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_BNZ: begin
                cw.branch_rel_nz = 1'b1;
                cw.pc_en         = 1'b1;
            end
            OP_JMP: begin
                cw.branch_abs = 1'b1;
                cw.pc_en      = 1'b1;
            end
            OP_JREG: begin
                // Jump target LUT is indexed by reg A rather than the immediate
                cw.branch_abs = 1'b1;
                cw.lut_in     = 1'b1;
                cw.pc_en      = 1'b1;
            end
            OP_SETPC: begin
                cw.alu_op       = ALU_PASS;
                cw.reg_sel      = 1'b1;
                cw.reg_write_en = 1'b1;
                cw.pc_en        = 1'b1;
            end
            OP_HALT: begin
                cw.is_halt = 1'b1;
            end
            default: begin
                cw.pc_en = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath.
// Define CTRL_SEQ_PERF_EN to add instr_count/cycle_count outputs.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int OPW     = 4
)
(
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           fcode,
    input  logic           dp_done,
    output logic           pc_en,
    output logic           CTRL_branch_rel_nz,
    output logic           CTRL_branch_rel_z,
    output logic           CTRL_branch_abs,
    output logic           CTRL_reg_write_en,
    output logic           CTRL_reg_sel,
    output logic           CTRL_lut_in,
    output logic           CTRL_mem_to_reg,
    output logic           CTRL_alu_src,
    output logic           CTRL_alu_sc_in,
    output logic           CTRL_read_mem,
    output logic           CTRL_write_mem,
    output logic [2:0]     CTRL_alu_op,
    output logic           busy,
    output logic           done
`ifdef CTRL_SEQ_PERF_EN
    ,
    output logic [15:0]    instr_count,
    output logic [15:0]    cycle_count
`endif
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    seq_state_t   state;
    seq_state_t   state_nx;
    logic [OPW:0] ir;
    logic [2:0]   cnt;
    opcode_t      ir_op;
    ctrl_word_t   cw;

    assign ir_op = opcode_t'(ir[OP_W:1]);

    ctrl_decode u_decode (
        .op    (ir_op),
        .fcode (ir[0]),
        .cw    (cw)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH) begin
                ir <= {opcode, fcode};
            end
            if (state == S_EXEC && cw.is_load) begin
                cnt <= LAT_INIT;
            end else if (state == S_MEM && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_comb begin
        state_nx           = state;
        pc_en              = 1'b0;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'd0;
        busy               = 1'b0;
        done               = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                busy               = 1'b1;
                pc_en              = cw.pc_en;
                CTRL_branch_rel_nz = cw.branch_rel_nz;
                CTRL_branch_rel_z  = cw.branch_rel_z;
                CTRL_branch_abs    = cw.branch_abs;
                CTRL_reg_write_en  = cw.reg_write_en;
                CTRL_reg_sel       = cw.reg_sel;
                CTRL_lut_in        = cw.lut_in;
                CTRL_alu_src       = cw.alu_src;
                CTRL_alu_sc_in     = cw.alu_sc_in;
                CTRL_read_mem      = cw.read_mem;
                CTRL_write_mem     = cw.write_mem;
                CTRL_alu_op        = cw.alu_op;
                if (cw.is_halt)      state_nx = S_HALT;
                else if (cw.is_load) state_nx = S_MEM;
                else                 state_nx = S_FETCH;
            end
            S_MEM: begin
                busy          = 1'b1;
                CTRL_read_mem = 1'b1;
                if (cnt == 3'd0) state_nx = S_WB;
            end
            S_WB: begin
                busy              = 1'b1;
                CTRL_mem_to_reg   = 1'b1;
                CTRL_reg_write_en = 1'b1;
                pc_en             = 1'b1;
                state_nx          = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) state_nx = S_FETCH;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Strobes of this cycle still go out; only the next state changes
        if (busy && dp_done) state_nx = S_HALT;
    end

`ifdef CTRL_SEQ_PERF_EN
    logic perf_clr;
    logic halt_entry;

    assign perf_clr   = start && (state == S_IDLE || state == S_HALT);
    assign halt_entry = busy && (state_nx == S_HALT);

    always_ff @(posedge CLK) begin
        if (reset || perf_clr) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if ((pc_en || halt_entry) && instr_count != 16'hFFFF) begin
                instr_count <= instr_count + 16'd1;
            end
            if (busy && cycle_count != 16'hFFFF) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer (MEM_LAT=3).
module tb_ctrl_sequencer;

    localparam int MEM_LAT = 3;

    localparam logic [16:0] B_BUSY = 17'h1 << 16;
    localparam logic [16:0] B_DONE = 17'h1 << 15;
    localparam logic [16:0] B_PC   = 17'h1 << 14;
    localparam logic [16:0] B_BNZ  = 17'h1 << 13;
    localparam logic [16:0] B_BZ   = 17'h1 << 12;
    localparam logic [16:0] B_BABS = 17'h1 << 11;
    localparam logic [16:0] B_WE   = 17'h1 << 10;
    localparam logic [16:0] B_RSEL = 17'h1 << 9;
    localparam logic [16:0] B_LUT  = 17'h1 << 8;
    localparam logic [16:0] B_M2R  = 17'h1 << 7;
    localparam logic [16:0] B_ASRC = 17'h1 << 6;
    localparam logic [16:0] B_SC   = 17'h1 << 5;
    localparam logic [16:0] B_RD   = 17'h1 << 4;
    localparam logic [16:0] B_WR   = 17'h1 << 3;

    localparam logic [16:0] A_ADD  = 17'd0;
    localparam logic [16:0] A_SUB  = 17'd1;
    localparam logic [16:0] A_AND  = 17'd2;
    localparam logic [16:0] A_OR   = 17'd3;
    localparam logic [16:0] A_XOR  = 17'd4;
    localparam logic [16:0] A_SHL  = 17'd5;
    localparam logic [16:0] A_SHR  = 17'd6;
    localparam logic [16:0] A_PASS = 17'd7;

    localparam logic [3:0] O_ADD  = 4'd0;
    localparam logic [3:0] O_LD   = 4'd7;
    localparam logic [3:0] O_ST   = 4'd8;
    localparam logic [3:0] O_HALT = 4'd15;

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic [16:0] exp;
        string       name;
    } vec_t;

    logic        CLK;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic        fcode;
    logic        dp_done;
    logic        pc_en;
    logic        br_nz;
    logic        br_z;
    logic        br_abs;
    logic        we;
    logic        rsel;
    logic        lut;
    logic        m2r;
    logic        asrc;
    logic        sc;
    logic        rd;
    logic        wr;
    logic [2:0]  alu_op;
    logic        busy;
    logic        done;
`ifdef CTRL_SEQ_PERF_EN
    logic [15:0] instr_count;
    logic [15:0] cycle_count;
`endif

    int   checks;
    int   failures;
    vec_t tbl [16];

    ctrl_sequencer #(.MEM_LAT(MEM_LAT), .OPW(4)) dut (
        .CLK                (CLK),
        .reset              (reset),
        .start              (start),
        .opcode             (opcode),
        .fcode              (fcode),
        .dp_done            (dp_done),
        .pc_en              (pc_en),
        .CTRL_branch_rel_nz (br_nz),
        .CTRL_branch_rel_z  (br_z),
        .CTRL_branch_abs    (br_abs),
        .CTRL_reg_write_en  (we),
        .CTRL_reg_sel       (rsel),
        .CTRL_lut_in        (lut),
        .CTRL_mem_to_reg    (m2r),
        .CTRL_alu_src       (asrc),
        .CTRL_alu_sc_in     (sc),
        .CTRL_read_mem      (rd),
        .CTRL_write_mem     (wr),
        .CTRL_alu_op        (alu_op),
        .busy               (busy),
        .done               (done)
`ifdef CTRL_SEQ_PERF_EN
        ,
        .instr_count        (instr_count),
        .cycle_count        (cycle_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [16:0] obs();
        return {busy, done, pc_en, br_nz, br_z, br_abs, we, rsel,
                lut, m2r, asrc, sc, rd, wr, alu_op};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input int n);
        opcode = op;
        fcode  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = '{4'd0,  1'b0, B_BUSY|B_PC|B_WE|A_ADD,         "add"};
        tbl[1]  = '{4'd0,  1'b1, B_BUSY|B_PC|B_WE|A_SUB,         "sub"};
        tbl[2]  = '{4'd1,  1'b1, B_BUSY|B_PC|B_WE|A_AND,         "and"};
        tbl[3]  = '{4'd2,  1'b0, B_BUSY|B_PC|B_WE|A_OR,          "or"};
        tbl[4]  = '{4'd3,  1'b0, B_BUSY|B_PC|B_WE|A_XOR,         "xor"};
        tbl[5]  = '{4'd4,  1'b1, B_BUSY|B_PC|B_WE|B_SC|A_SHL,    "shl_f1"};
        tbl[6]  = '{4'd5,  1'b0, B_BUSY|B_PC|B_WE|A_SHR,         "shr_f0"};
        tbl[7]  = '{4'd5,  1'b1, B_BUSY|B_PC|B_WE|B_SC|A_SHR,    "shr_f1"};
        tbl[8]  = '{4'd6,  1'b0, B_BUSY|B_PC|B_WE|B_ASRC|A_ADD,  "addi"};
        tbl[9]  = '{4'd8,  1'b0, B_BUSY|B_PC|B_WR|A_ADD,         "st"};
        tbl[10] = '{4'd9,  1'b0, B_BUSY|B_PC|B_BZ|A_ADD,         "bz"};
        tbl[11] = '{4'd10, 1'b0, B_BUSY|B_PC|B_BNZ|A_ADD,        "bnz"};
        tbl[12] = '{4'd11, 1'b0, B_BUSY|B_PC|B_BABS|A_ADD,       "jmp"};
        tbl[13] = '{4'd12, 1'b0, B_BUSY|B_PC|B_BABS|B_LUT|A_ADD, "jreg"};
        tbl[14] = '{4'd13, 1'b0, B_BUSY|B_PC|B_WE|B_RSEL|A_PASS, "setpc"};
        tbl[15] = '{4'd14, 1'b0, B_BUSY|B_PC|A_ADD,              "nop"};

        reset   = 1'b1;
        start   = 1'b1;
        opcode  = 4'd0;
        fcode   = 1'b0;
        dp_done = 1'b0;
        tick();
        tick();
        chk("reset_start_held", obs(), 17'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_reset", obs(), 17'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_to_fetch", obs(), B_BUSY);

        for (int i = 0; i < 16; i++) begin
            opcode = tbl[i].op;
            fcode  = tbl[i].fc;
            tick();
            chk($sformatf("%s_exec", tbl[i].name), obs(), tbl[i].exp);
            tick();
            chk($sformatf("%s_fetch", tbl[i].name), obs(), B_BUSY);
        end

        opcode = O_LD;
        fcode  = 1'b0;
        tick();
        chk("ld_exec", obs(), B_BUSY|B_RD);
        start = 1'b1;
        for (int k = 0; k < MEM_LAT; k++) begin
            tick();
            chk($sformatf("ld_mem%0d", k), obs(), B_BUSY|B_RD);
        end
        start = 1'b0;
        tick();
        chk("ld_wb", obs(), B_BUSY|B_PC|B_WE|B_M2R);
        tick();
        chk("ld_fetch", obs(), B_BUSY);

        opcode = O_HALT;
        tick();
        chk("halt_exec", obs(), B_BUSY);
        tick();
        chk("halt_state", obs(), B_DONE);
        tick();
        chk("halt_hold", obs(), B_DONE);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_restart", obs(), B_BUSY);

        opcode = O_ADD;
        tick();
        dp_done = 1'b1;
        chk("dpdone_exec_commit", obs(), B_BUSY|B_PC|B_WE|A_ADD);
        tick();
        dp_done = 1'b0;
        chk("dpdone_exec_halt", obs(), B_DONE);

        start = 1'b1;
        tick();
        start  = 1'b0;
        opcode = O_LD;
        tick();
        tick();
        chk("dpdone_mem_pre", obs(), B_BUSY|B_RD);
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("dpdone_mem_halt", obs(), B_DONE);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("reset_mid_ld", obs(), 17'd0);
        reset = 1'b0;
        tick();
        chk("reset_mid_idle", obs(), 17'd0);

`ifdef CTRL_SEQ_PERF_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        run(O_ADD, 2);
        run(O_ST, 2);
        run(O_LD, 3 + MEM_LAT);
        run(O_HALT, 2);
        chk("perf_done", obs(), B_DONE);
        chk("perf_instr", {1'b0, instr_count}, 17'd4);
        chk("perf_cycles", {1'b0, cycle_count}, 17'(2 + 2 + 3 + MEM_LAT + 2));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("perf_clr_instr", {1'b0, instr_count}, 17'd0);
        chk("perf_clr_cycles", {1'b0, cycle_count}, 17'd0);
`else
        run(O_ADD, 1);
        chk("idle_ignores_op", obs(), 17'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle control FSM for the 8-bit accumulator-style datapath. It latches the 4-bit opcode and fcode from instruction ROM output and drives every CTRL_* strobe of the datapath. It also issues a one-cycle PC advance per instruction and stretches loads over a configurable data-memory latency. It sits beside the datapath in the top level, started by a start pulse and finished on HALT or the datapath's DONE.

Parameters:
MEM_LAT, 1, data_mem read latency in cycles (1..7); load holds in MEM state this many cycles
OPW, 4, opcode width

Ports:
CLK  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  pulse; begins execution from IDLE or HALT
opcode  input  OPW  instruction opcode field from the datapath
fcode  input  1  function bit (instr bit 0)
dp_done  input  1  DONE from the fetch unit
pc_en  output  1  one-cycle PC advance/branch commit
CTRL_branch_rel_nz  output  1  relative branch if flag ZERO==0
CTRL_branch_rel_z  output  1  relative branch if flag ZERO==1
CTRL_branch_abs  output  1  absolute jump
CTRL_reg_write_en  output  1  register file write
CTRL_reg_sel  output  1  select REG_PC as register A
CTRL_lut_in  output  1  LUT index from reg A instead of immediate
CTRL_mem_to_reg  output  1  write-back from data memory
CTRL_alu_src  output  1  ALU B = 3-bit immediate
CTRL_alu_sc_in  output  1  ALU carry/shift-in
CTRL_read_mem  output  1  data memory read
CTRL_write_mem  output  1  data memory write
CTRL_alu_op  output  3  ALU operation
busy  output  1  high in FETCH/EXEC/MEM/WB
done  output  1  high in HALT

Behaviour:
- Reset: state=IDLE; every output 0; IR and latency counter cleared. Reset wins over start in the same cycle.
- States:
  - IDLE: start -> FETCH.
  - FETCH: latch {opcode,fcode} into IR; -> EXEC.
  - EXEC: decode IR.
    - ALU/ADDI/SETPC: assert write_en and pc_en; -> FETCH.
    - ST: write_mem=1 and pc_en=1 for one cycle; -> FETCH.
    - BZ/BNZ/JMP/JREG: branch strobe and pc_en; -> FETCH.
    - LD: read_mem=1; load counter with MEM_LAT-1; -> MEM.
    - HALT opcode: -> HALT with no pc_en.
  - MEM: read_mem held; counter decrements; at 0 -> WB.
  - WB: mem_to_reg=1, write_en=1, pc_en=1; -> FETCH.
  - HALT: done=1; start -> FETCH.
- Timing: CTRL_* are combinational from state and IR, and are 0 outside EXEC/MEM/WB. write_en, write_mem and pc_en are never high for more than one cycle per instruction.
- Latency: ALU, ST and branch take 2 cycles. LD takes 3+MEM_LAT cycles (FETCH, EXEC, MEM×MEM_LAT, WB).
- dp_done high in any busy state -> HALT at the next edge. Any pending write in that cycle still commits.
- start while busy is ignored. Reset mid-instruction aborts it with no write or pc_en.
- Unused opcodes execute as NOP: pc_en only.
- fcode: selects alu_sc_in for shift ops and selects SUB vs ADD for opcode ADD.

Optional Feature:
CTRL_SEQ_PERF_EN
- Defined: adds outputs instr_count[15:0] and cycle_count[15:0].
  - instr_count increments on each pc_en or HALT entry.
  - cycle_count increments every busy cycle.
  - Both saturate at 16'hFFFF and clear on reset or on start from IDLE/HALT.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package definitions holds:
  - opcode enum: ADD=0, AND, OR, XOR, SHL, SHR, ADDI, LD, ST, BZ, BNZ, JMP, JREG, SETPC, NOP=14, HALT=15
  - ALU op enum (3-bit)
  - seq_state_t enum
  - REG_PC constant
- One natural combinational sub-module, ctrl_decode: maps IR to a control-word struct defined in the package. ctrl_sequencer gates that struct by state.

Test Plan:
- Reset with start held high -> state stays IDLE, all outputs 0, busy=0, done=0.
- start; opcode=ADD, fcode=0 -> FETCH, then EXEC with alu_op=ADD, write_en=1, pc_en=1 for exactly 1 cycle, busy for 2 cycles.
- MEM_LAT=3; opcode=LD:
  - read_mem high for cycles 2..5.
  - WB on cycle 6 with mem_to_reg=1, write_en=1, pc_en=1.
- opcode=BZ -> EXEC asserts branch_rel_z=1 and pc_en=1 only; write_en=0, write_mem=0.
- opcode=HALT -> done=1 with no pc_en; next start -> FETCH. Separately, dp_done=1 during MEM -> HALT next cycle.
- PERF build, program ADD,ST,LD(MEM_LAT=1),HALT -> instr_count=4, cycle_count=2+2+4+2=10.
